operand_sequencer: RTL
======================

# operand_sequencer

Sequences the operand field of one assembly source line after the mnemonic has been decoded. Accepts the ASCII character stream from the line buffer and strips inter-operand whitespace and commas. Routes each operand's characters to either the register or the immediate interpreter, collects their results into three operand registers, and reports a single done or error per instruction. Sits between the line buffer / mnemonic decoder and the operand sub-interpreters in the assembler front end.

## Interface
- TIMEOUT_CYCLES, 255: idle cycles without an accepted character, while busy, before a timeout error is raised.
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-high reset
- start  in  1  begin an instruction; sampled only in IDLE
- op_count  in  2  number of operands, 0–3; latched on start
- op_kinds  in  3  bit i=1: operand i is an immediate; bit i=0: operand i is a register; latched on start
- char_valid  in  1  char_in is valid
- char_in  in  8  ASCII character
- char_ready  out  1  the character is consumed this cycle when char_valid && char_ready
- reg_valid, imm_valid  out  1  forward strobe to the register / immediate interpreter
- sub_ascii  out  8  forwarded character, shared by both interpreters
- sub_clear  out  1  one-cycle pulse on accepted start; clears both interpreters
- reg_done, reg_error  in  1  register interpreter flags
- reg_value  in  5  register index
- imm_done, imm_error  in  1  immediate interpreter flags
- imm_value  in  32  immediate value
- op0, op1, op2  out  32  collected operands; register indices are zero-extended
- busy  out  1  high whenever not IDLE
- done  out  1  one-cycle pulse on success
- error  out  1  one-cycle pulse on failure
- err_code  out  2  1 = bad separator, 2 = sub-interpreter error, 3 = timeout; held until the next accepted start

## Operation
- Reset: state IDLE. All outputs 0, including op0–op2, err_code, idx and the timeout counter.
- idx is a 2-bit operand index.
- IDLE: char_ready=0.
  - On start: latch op_count and op_kinds; clear op0–op2, err_code and idx; pulse sub_clear.
  - Next state is LEAD if op_count>0, otherwise TAIL.
- LEAD: a space (0x20) is consumed. Any other valid char is not consumed (char_ready=0), and the state goes to ROUTE.
- ROUTE: char_ready=1.
  - An accepted char is forwarded combinationally: sub_ascii=char_in, and the strobe is asserted on the interpreter selected by op_kinds[idx].
  - The state then goes to CHECK.
  - Spaces are forwarded too; legality is the interpreter's decision.
- CHECK: char_ready=0. Sample the selected interpreter's flags (error has priority).
  - error -> ERROR with code 2.
  - done -> write the value to op[idx] and increment idx. If idx+1 == op_count, go to TAIL; otherwise go to SEP.
  - Neither flag -> ROUTE.
- SEP: consumes spaces until one ',' is consumed, then goes to LEAD. Any other char is consumed and gives ERROR with code 1.
- TAIL: consumes spaces. '\n' (0x0A) is consumed and goes to DONE. Any other char is consumed and gives ERROR with code 1.
- DONE: pulse done, then go to IDLE.
- ERROR: pulse error, then go to IDLE. The op registers keep their partial contents.
- Timeout: in LEAD/ROUTE/SEP/TAIL, the counter increments on every cycle with char_valid=0 and clears on any accepted char or on entry to CHECK. Reaching TIMEOUT_CYCLES gives ERROR with code 3.
- The unselected interpreter's strobe is always 0. No strobe is asserted outside ROUTE.
- Sub-interpreter contract: done/error are valid the cycle after the strobed character and are ignored at all other times.

## Timing
- Throughput: 2 cycles per operand character (ROUTE + CHECK); 1 cycle per whitespace or separator character.
- Start to first char_ready: 2 cycles (IDLE -> LEAD -> ROUTE when the first char is not a space).
- done/error are asserted the cycle after the terminating event and last exactly 1 cycle. busy is low the cycle after the pulse.
- start while busy: ignored.
- rst_in mid-instruction: immediate return to IDLE, all outputs cleared, no done or error pulse.
- The done or error pulse and the next start may be back-to-back: start is accepted in the IDLE cycle that follows the pulse.

## Test plan
- op_count=2, op_kinds=3'b010, stream "x5, '1F'\n"; model reg returns 5, model imm returns 0x1F -> done; op0=5, op1=0x0000001F, op2=0, err_code=0.
- op_count=0, stream "  \n" -> done 4 cycles after start; op0–op2=0; no strobe asserted on either interpreter.
- op_count=2, stream "x5 x6\n" -> error with err_code=1 when 'x' is seen in SEP; op0=5 retained.
- op_count=1, kinds=1, imm model asserts imm_error after the third character -> error with err_code=2 exactly 1 cycle after that CHECK.
- TIMEOUT_CYCLES=8, op_count=1, char_valid held low after start -> error with err_code=3 after 8 idle cycles in LEAD.
- rst_in pulsed during ROUTE of op1 -> same-cycle busy=0, op0=0, no pulse; a following start with stream "x1\n" completes normally with op0=1.

Source files
------------

// File: rtl/operand_sequencer.sv
// Operand-field sequencer for the assembler front end: strips separators, routes
// operand characters to the register/immediate interpreters and collects results.
module operand_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start,
    input  logic [1:0]  op_count,
    input  logic [2:0]  op_kinds,
    input  logic        char_valid,
    input  logic [7:0]  char_in,
    output logic        char_ready,
    output logic        reg_valid,
    output logic        imm_valid,
    output logic [7:0]  sub_ascii,
    output logic        sub_clear,
    input  logic        reg_done,
    input  logic        reg_error,
    input  logic [4:0]  reg_value,
    input  logic        imm_done,
    input  logic        imm_error,
    input  logic [31:0] imm_value,
    output logic [31:0] op0,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);

    localparam int         CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [1:0] E_SEP    = 2'd1;
    localparam logic [1:0] E_SUB    = 2'd2;
    localparam logic [1:0] E_TMO    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD, S_ROUTE, S_CHECK, S_SEP, S_TAIL, S_DONE, S_ERROR
    } state_t;

    state_t        state, state_next;
    logic [1:0]    count_q;
    logic [2:0]    kinds_q;
    logic [1:0]    idx;
    logic [CW-1:0] tmo;

    logic [3:0]  kinds_ext;
    logic        sel_imm;
    logic        flag_done;
    logic        flag_err;
    logic [31:0] sub_value;
    logic        load_op;
    logic        set_err;
    logic [1:0]  err_next;
    logic        waiting;
    logic        tmo_wait;

    // idx can reach 3 after the last operand; the padded bit keeps the select in range.
    assign kinds_ext = {1'b0, kinds_q};
    assign sel_imm   = kinds_ext[idx];
    assign flag_done = sel_imm ? imm_done  : reg_done;
    assign flag_err  = sel_imm ? imm_error : reg_error;
    assign sub_value = sel_imm ? imm_value : {27'd0, reg_value};

    assign waiting  = (state == S_LEAD) || (state == S_ROUTE) ||
                      (state == S_SEP)  || (state == S_TAIL);
    assign tmo_wait = waiting && !char_valid;

    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);
    assign error = (state == S_ERROR);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        char_ready = 1'b0;
        reg_valid  = 1'b0;
        imm_valid  = 1'b0;
        sub_ascii  = 8'd0;
        sub_clear  = 1'b0;
        load_op    = 1'b0;
        set_err    = 1'b0;
        err_next   = 2'd0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    sub_clear  = 1'b1;
                    state_next = (op_count != 2'd0) ? S_LEAD : S_TAIL;
                end
            end
            S_LEAD: begin
                if (char_valid) begin
                    if (char_in == CH_SPACE) char_ready = 1'b1;
                    else                     state_next = S_ROUTE;
                end
            end
            S_ROUTE: begin
                char_ready = 1'b1;
                if (char_valid) begin
                    sub_ascii  = char_in;
                    reg_valid  = !sel_imm;
                    imm_valid  = sel_imm;
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (flag_err) begin
                    set_err    = 1'b1;
                    err_next   = E_SUB;
                    state_next = S_ERROR;
                end else if (flag_done) begin
                    load_op    = 1'b1;
                    state_next = (2'(idx + 2'd1) == count_q) ? S_TAIL : S_SEP;
                end else begin
                    state_next = S_ROUTE;
                end
            end
            S_SEP: begin
                char_ready = 1'b1;
                if (char_valid) begin
                    if (char_in == CH_COMMA) begin
                        state_next = S_LEAD;
                    end else if (char_in != CH_SPACE) begin
                        set_err    = 1'b1;
                        err_next   = E_SEP;
                        state_next = S_ERROR;
                    end
                end
            end
            S_TAIL: begin
                char_ready = 1'b1;
                if (char_valid) begin
                    if (char_in == CH_NL) begin
                        state_next = S_DONE;
                    end else if (char_in != CH_SPACE) begin
                        set_err    = 1'b1;
                        err_next   = E_SEP;
                        state_next = S_ERROR;
                    end
                end
            end
            S_DONE, S_ERROR: state_next = S_IDLE;
            default:         state_next = S_IDLE;
        endcase
        if (tmo_wait && (tmo == CW'(TIMEOUT_CYCLES - 1))) begin
            set_err    = 1'b1;
            err_next   = E_TMO;
            state_next = S_ERROR;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_q  <= 2'd0;
            kinds_q  <= 3'd0;
            idx      <= 2'd0;
            tmo      <= '0;
            op0      <= 32'd0;
            op1      <= 32'd0;
            op2      <= 32'd0;
            err_code <= 2'd0;
        end else begin
            if (state == S_IDLE && start) begin
                count_q  <= op_count;
                kinds_q  <= op_kinds;
                idx      <= 2'd0;
                op0      <= 32'd0;
                op1      <= 32'd0;
                op2      <= 32'd0;
                err_code <= 2'd0;
            end
            if (load_op) begin
                case (idx)
                    2'd0:    op0 <= sub_value;
                    2'd1:    op1 <= sub_value;
                    2'd2:    op2 <= sub_value;
                    default: ;
                endcase
                idx <= idx + 2'd1;
            end
            if (set_err) err_code <= err_next;

            // A valid-but-unconsumed char in LEAD holds the count rather than clearing it.
            if (tmo_wait)
                tmo <= tmo + 1'b1;
            else if (!waiting || (char_valid && char_ready))
                tmo <= '0;
        end
    end

endmodule
